// File: rtl/addac_pkg.sv
// Shared types for the addac command sequencer and its accumulator load.
package addac_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_RADD = 2'b11
  } op_e;

  // Encoding is {sel1, sel0} as seen by the accumulator.
  typedef enum logic [1:0] {
    SEL_HOLD = 2'b00,
    SEL_LOAD = 2'b01,
    SEL_ADD  = 2'b10,
    SEL_SUB  = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_STEP = 2'b01,
    S_CAPT = 2'b10,
    S_RESP = 2'b11
  } state_e;

  // Accumulator select used while stepping a command; RADD is a chain of ADDs.
  function automatic sel_e op2sel(op_e op);
    case (op)
      OP_LOAD: op2sel = SEL_LOAD;
      OP_ADD:  op2sel = SEL_ADD;
      OP_SUB:  op2sel = SEL_SUB;
      default: op2sel = SEL_ADD;
    endcase
  endfunction

endpackage

// File: rtl/addac_seq_if.sv
// Command / response channel between a requester and the addac sequencer.
interface addac_seq_if import addac_pkg::*; #(
  parameter int W     = 4,
  parameter int CNT_W = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  op_e              cmd_op;
  logic [W-1:0]     cmd_data;
  logic [CNT_W-1:0] cmd_cnt;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_data;
  logic             rsp_carry;
  logic             rsp_carry_any;

  // Requester side.
  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_cnt, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_carry_any
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_cnt, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_carry_any
  );

endinterface

// File: rtl/addac4.sv
// Single accumulator lane driven by the sequencer: HOLD/LOAD/ADD/SUB.
// Deliberately has no reset; its value is undefined until the first LOAD.
module addac4 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic [W-1:0] a,
  input  logic         sel0,
  input  logic         sel1,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] sum;

  // Sum for ADD or two's-complement SUB, with the carry out in the top bit.
  always_comb begin
    sum = '0;
    if (sel0) sum = {1'b0, s} + {1'b0, ~a} + {{W{1'b0}}, 1'b1};
    else      sum = {1'b0, s} + {1'b0, a};
  end

  // Register the accumulator and its carry according to {sel1, sel0}.
  always_ff @(posedge clk) begin
    case ({sel1, sel0})
      2'b01: begin
        s    <= a;
        cout <= 1'b0;
      end
      2'b10, 2'b11: begin
        s    <= sum[W-1:0];
        cout <= sum[W];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/addac_seq.sv
// Command sequencer for the addac accumulator: accepts one command, steps the
// accumulator cycle by cycle, captures the result and holds it on the
// response channel until it is consumed.
module addac_seq import addac_pkg::*; #(
  parameter int W     = 4,
  parameter int CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  addac_seq_if.slave   cmd_if,
  output logic         busy,
  output logic [W-1:0] acc_a,
  output logic         acc_sel0,
  output logic         acc_sel1,
  input  logic [W-1:0] acc_s,
  input  logic         acc_cout
);

  state_e           state_q;
  op_e              op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             first_q;
  logic             any_q;
  sel_e             sel_q;
  logic [W-1:0]     a_q;
  logic             rsp_valid_q;
  logic [W-1:0]     rsp_data_q;
  logic             rsp_carry_q;
  logic             rsp_any_q;

  // A zero-count RADD never touches the accumulator, so it reports no carry.
  logic             radd_zero;
  assign radd_zero = (op_q == OP_RADD) && (cnt_q == '0);

  // Sequencer FSM; all accumulator drive and response fields are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LOAD;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      any_q       <= 1'b0;
      sel_q       <= SEL_HOLD;
      a_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_any_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_if.cmd_valid) begin
            op_q    <= cmd_if.cmd_op;
            cnt_q   <= cmd_if.cmd_cnt;
            first_q <= 1'b1;
            any_q   <= 1'b0;
            if (cmd_if.cmd_op == OP_RADD && cmd_if.cmd_cnt == '0) begin
              state_q <= S_CAPT;
            end else begin
              state_q <= S_STEP;
              sel_q   <= op2sel(cmd_if.cmd_op);
              a_q     <= cmd_if.cmd_data;
            end
          end
        end
        S_STEP: begin
          first_q <= 1'b0;
          // acc_cout only reflects a step of this command from the 2nd step on.
          if (!first_q) any_q <= any_q | acc_cout;
          if (op_q == OP_RADD && cnt_q > CNT_W'(1)) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= S_CAPT;
            sel_q   <= SEL_HOLD;
            a_q     <= '0;
          end
        end
        S_CAPT: begin
          rsp_data_q  <= acc_s;
          rsp_carry_q <= radd_zero ? 1'b0 : acc_cout;
          rsp_any_q   <= radd_zero ? 1'b0 : (any_q | acc_cout);
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (cmd_if.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_if.cmd_ready     = (state_q == S_IDLE);
  assign busy                 = (state_q != S_IDLE);
  assign cmd_if.rsp_valid     = rsp_valid_q;
  assign cmd_if.rsp_data      = rsp_data_q;
  assign cmd_if.rsp_carry     = rsp_carry_q;
  assign cmd_if.rsp_carry_any = rsp_any_q;
  assign acc_a                = a_q;
  assign acc_sel0             = sel_q[0];
  assign acc_sel1             = sel_q[1];

endmodule

// File: tb/tb_addac_seq.sv
// Bench for addac_seq driving an addac4 accumulator; directed cases then
// random commands checked against an arithmetic reference model.
module tb_addac_seq;
  import addac_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [3:0] acc_a;
  logic       acc_sel0;
  logic       acc_sel1;
  logic [3:0] acc_s;
  logic       acc_cout;

  int total = 0;
  int bad   = 0;

  logic [3:0] m_acc;

  addac_seq_if #(.W(4), .CNT_W(4)) bus ();

  addac_seq #(.W(4), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_if   (bus),
    .busy     (busy),
    .acc_a    (acc_a),
    .acc_sel0 (acc_sel0),
    .acc_sel1 (acc_sel1),
    .acc_s    (acc_s),
    .acc_cout (acc_cout)
  );

  addac4 #(.W(4)) u_acc (
    .clk  (clk),
    .a    (acc_a),
    .sel0 (acc_sel0),
    .sel1 (acc_sel1),
    .s    (acc_s),
    .cout (acc_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Issue one command, check stepping, latency and result, optionally stall the
  // response for `hold` cycles; `keep` offers a LOAD 7 during the stall.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] d, input logic [3:0] n,
                        input int hold, input bit keep);
    int nst, lat, k;
    bit seen;
    logic [1:0] esel;
    logic [3:0] ed;
    logic ec, ea;
    logic [4:0] t;
    ec = 1'b0; ea = 1'b0;
    case (op)
      2'd0: begin nst = 1; lat = 2; esel = 2'b01; m_acc = d; end
      2'd1: begin
        nst = 1; lat = 2; esel = 2'b10;
        t = {1'b0, m_acc} + {1'b0, d}; m_acc = t[3:0]; ec = t[4]; ea = ec;
      end
      2'd2: begin
        nst = 1; lat = 2; esel = 2'b11;
        t = {1'b0, m_acc} + 5'd16 - {1'b0, d}; m_acc = t[3:0]; ec = t[4]; ea = ec;
      end
      default: begin
        nst = int'(n); lat = (n == 0) ? 1 : int'(n) + 1; esel = 2'b10;
        for (int i = 0; i < int'(n); i++) begin
          t = {1'b0, m_acc} + {1'b0, d}; m_acc = t[3:0]; ec = t[4]; ea = ea | ec;
        end
      end
    endcase
    ed = m_acc;

    bus.cmd_op = op_e'(op); bus.cmd_data = d; bus.cmd_cnt = n; bus.cmd_valid = 1'b1;
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    @(posedge clk); @(negedge clk);
    bus.cmd_valid = 1'b0;
    k = 0; seen = 0;
    while (k < 40 && !seen) begin
      if (bus.rsp_valid) seen = 1;
      else begin
        chk("sel", {acc_sel1, acc_sel0}, (k < nst) ? esel : 2'b00);
        if (k < nst) chk("acc_a", acc_a, d);
        k++;
        @(negedge clk);
      end
    end
    if (!seen) chk("rsp_timeout", 0, 1);
    else       chk("latency", k, lat);
    chk("rsp_data", bus.rsp_data, ed);
    chk("rsp_carry", bus.rsp_carry, ec);
    chk("rsp_carry_any", bus.rsp_carry_any, ea);
    chk("busy_resp", busy, 1);
    chk("cmd_ready_resp", bus.cmd_ready, 0);

    if (keep) begin
      bus.cmd_op = OP_LOAD; bus.cmd_data = 4'd7; bus.cmd_cnt = 4'd0; bus.cmd_valid = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", bus.rsp_valid, 1);
      chk("hold_data", {bus.rsp_data, bus.rsp_carry, bus.rsp_carry_any}, {ed, ec, ea});
      chk("hold_cmd_ready", bus.cmd_ready, 0);
      chk("hold_sel", {acc_sel1, acc_sel0}, 2'b00);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_drop", bus.rsp_valid, 0);
    chk("cmd_ready_back", bus.cmd_ready, 1);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = OP_LOAD; bus.cmd_data = '0; bus.cmd_cnt = '0;
    bus.rsp_ready = 1'b0;
    m_acc = '0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp", {bus.rsp_data, bus.rsp_carry, bus.rsp_carry_any}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel", {acc_sel1, acc_sel0}, 0);
    chk("rst_acc_a", acc_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: load/add/sub, repeated add, zero count, stall with pending cmd.
    do_cmd(2'd0, 4'd5, 4'd0, 0, 0);
    do_cmd(2'd1, 4'hC, 4'd0, 0, 0);
    do_cmd(2'd2, 4'd3, 4'd0, 0, 0);
    do_cmd(2'd0, 4'd0, 4'd0, 0, 0);
    do_cmd(2'd3, 4'd3, 4'd6, 0, 0);
    do_cmd(2'd0, 4'd0, 4'd0, 0, 0);
    do_cmd(2'd3, 4'd3, 4'd5, 0, 0);
    do_cmd(2'd0, 4'd9, 4'd0, 0, 0);
    do_cmd(2'd3, 4'd2, 4'd0, 0, 0);
    do_cmd(2'd1, 4'd1, 4'd0, 4, 1);
    do_cmd(2'd0, 4'd7, 4'd0, 0, 0);
    do_cmd(2'd3, 4'd1, 4'd15, 1, 0);

    // Reset during the 3rd step of RADD cnt=8.
    bus.cmd_op = OP_RADD; bus.cmd_data = 4'd1; bus.cmd_cnt = 4'd8; bus.cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("step3_sel", {acc_sel1, acc_sel0}, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", {acc_sel1, acc_sel0}, 0);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_acc_a", acc_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", bus.cmd_ready, 1);
    do_cmd(2'd0, 4'd4, 4'd0, 0, 0);

    // Random commands against the reference model.
    for (int i = 0; i < 40; i++) begin
      do_cmd(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 2)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
